uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer between NUM_REQ byte producers, e.g. the console, debug monitor and loader.
- Grants requesters round-robin and latches the winner's byte.
- Issues a one-cycle send_request to the serializer, then waits for frame completion.
- Enforces an inter-frame gap counted in baud ticks, and has a watchdog so a dead serializer does not hang the arbiter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_TICKS, 1, idle baud ticks inserted after each frame (0 = no gap).
- TIMEOUT_CYCLES, 1024, clk cycles allowed in WAIT_START or WAIT_DONE before abort.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- baud_tick  input  1  one-clk pulse per bit period, from baud_gen.
- req_valid  input  NUM_REQ  requester k has a byte pending.
- req_data  input  8*NUM_REQ  byte of requester k, at bits [8k+7:8k].
- req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse; the byte is taken when valid&ready.
- tx_data  output  8  byte to serializer; held stable from ISSUE until the frame ends.
- send_request  output  1  one-cycle start pulse to serializer.
- tx_busy  input  1  serializer frame in progress.
- tx_done  input  1  one-cycle frame-complete pulse from serializer.
- grant_id  output  $clog2(NUM_REQ)  index of the last/current granted requester.
- arb_busy  output  1  high in every state except IDLE.
- timeout_err  output  1  sticky; set on watchdog abort; cleared only by reset.

Behaviour:
- Reset values: req_ready=0, send_request=0, tx_data=8'h00, grant_id=0, arb_busy=0, timeout_err=0, state=IDLE, rr_ptr=0, counters=0.
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE, GAP.
- IDLE:
  - If any req_valid, pick the first set bit scanning from rr_ptr upward, with wrap-around.
  - In the same cycle, pulse req_ready[k] and latch req_data[k] into tx_data.
  - Set grant_id=k and rr_ptr=(k+1) mod NUM_REQ, then go to ISSUE.
  - Acceptance latency: one cycle from valid to ready when idle.
- ISSUE: send_request=1 for exactly this cycle; go to WAIT_START and clear the watchdog.
- WAIT_START:
  - On tx_busy=1, go to WAIT_DONE and clear the watchdog.
  - If tx_done=1 arrives first (fast serializer), treat the frame as complete and go to GAP.
- WAIT_DONE:
  - Completion is tx_done=1, or a 1->0 transition of tx_busy, whichever occurs first. Go to GAP.
  - Both events in the same cycle count as one completion.
- Watchdog: in WAIT_START/WAIT_DONE it counts clk cycles. When it reaches TIMEOUT_CYCLES, set timeout_err=1 and go to GAP. No retry; the byte is dropped.
- GAP:
  - Count baud_tick pulses; after GAP_TICKS ticks go to IDLE.
  - With GAP_TICKS=0, go to IDLE on the next clk.
  - baud_tick arriving in the GAP entry cycle counts.
- send_request is never asserted while tx_busy=1 and the arbiter is not in ISSUE; at most one byte is in flight.
- req_valid deasserting after acceptance has no effect.
- req_valid for a non-granted requester is ignored until IDLE.
- Reset mid-frame: all outputs return to reset values immediately (async). The in-flight byte is lost. The serializer is reset by the same signal.
- Watchdog counter width: $clog2(TIMEOUT_CYCLES+1). GAP counter width: $clog2(GAP_TICKS+1), minimum 1.

Optional Feature:
- Macro: UART_TX_ARB_LOCK_EN.
- When defined:
  - Adds input req_lock[NUM_REQ-1:0].
  - If the granted requester holds req_lock=1 on leaving GAP, it is granted again ahead of round-robin and rr_ptr is not advanced. This keeps multi-byte packets contiguous.
  - Lock is honoured only if that requester's req_valid=1 in IDLE; otherwise normal round-robin resumes.
- When undefined: there is no req_lock port and arbitration is pure round-robin.

Test Plan:
- Single byte: req_valid[0] with 8'hA5, idle arbiter, GAP_TICKS=1 -> req_ready[0] pulses 1 cycle, send_request pulses the next cycle, tx_data=8'hA5 held until tx_done, arb_busy falls one baud_tick after completion.
- Round-robin: req_valid=4'b1111 held with bytes 8'h10..8'h13 -> grant order 0,1,2,3,0; grant_id matches; exactly one send_request per frame.
- Wrap: rr_ptr=3, req_valid=4'b0101 -> requester 0 granted, then 2.
- Timeout: tx_busy stuck 0 and no tx_done, TIMEOUT_CYCLES=16 -> timeout_err=1 exactly 16 cycles after ISSUE; arbiter returns to IDLE and serves the next request; timeout_err stays 1.
- Reset mid-operation: assert reset in WAIT_DONE -> all outputs return to reset values the same cycle; after release, a pending req_valid[2] is granted first (rr_ptr=0 scan).
- Lock (UART_TX_ARB_LOCK_EN): req_lock[1]=1, req_valid=4'b0011 for 3 bytes -> requester 1 gets 3 consecutive frames, then requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between NUM_REQ byte producers.
// Optional `UART_TX_ARB_LOCK_EN adds req_lock for back-to-back packet grants.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned GAP_TICKS      = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       baud_tick,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
`ifdef UART_TX_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]         req_lock,
`endif
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       send_request,
    input  logic                       tx_busy,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       arb_busy,
    output logic                       timeout_err
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GW  = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    localparam logic [WDW-1:0] WD_LIMIT  = WDW'(TIMEOUT_CYCLES);
    localparam logic [GW-1:0]  GAP_LIMIT = GW'(GAP_TICKS);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE,
        GAP
    } state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] req_ready_q;
    logic [7:0]         tx_data_q;
    logic               send_q;
    logic [IDW-1:0]     grant_q;
    logic               timeout_q;
    logic [IDW-1:0]     rr_q;
    logic [WDW-1:0]     wd_q;
    logic [WDW-1:0]     wd_d;
    logic [GW-1:0]      gap_q;
    logic [GW-1:0]      gap_d;
    logic               busy_q;
`ifdef UART_TX_ARB_LOCK_EN
    logic               lock_hold_q;
`endif

    logic               pick_found;
    logic [IDW-1:0]     pick_idx;
    logic               sel_found;
    logic [IDW-1:0]     sel_idx;
    logic               sel_adv;

    assign wd_d  = wd_q + WDW'(1);
    assign gap_d = gap_q + GW'(1);

    // First valid requester at or after rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            int unsigned idx;
            idx = int'(rr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick_idx   = IDW'(idx);
            end
        end
    end

    always_comb begin
        sel_found = pick_found;
        sel_idx   = pick_idx;
        sel_adv   = 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
        if (lock_hold_q && req_valid[grant_q]) begin
            sel_found = 1'b1;
            sel_idx   = grant_q;
            sel_adv   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_ready_q <= '0;
            tx_data_q   <= '0;
            send_q      <= 1'b0;
            grant_q     <= '0;
            timeout_q   <= 1'b0;
            rr_q        <= '0;
            wd_q        <= '0;
            gap_q       <= '0;
            busy_q      <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
            lock_hold_q <= 1'b0;
`endif
        end else begin
            busy_q      <= tx_busy;
            req_ready_q <= '0;
            send_q      <= 1'b0;
            case (state_q)
                IDLE: begin
`ifdef UART_TX_ARB_LOCK_EN
                    lock_hold_q <= 1'b0;
`endif
                    if (sel_found) begin
                        req_ready_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
                        tx_data_q   <= req_data[{sel_idx, 3'b000} +: 8];
                        grant_q     <= sel_idx;
                        if (sel_adv) rr_q <= (sel_idx == LAST_ID) ? '0 : sel_idx + IDW'(1);
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    send_q  <= 1'b1;
                    wd_q    <= '0;
                    state_q <= WAIT_START;
                end
                WAIT_START: begin
                    if (tx_done) begin
                        gap_q   <= '0;
                        state_q <= GAP;
                    end else if (tx_busy) begin
                        wd_q    <= '0;
                        state_q <= WAIT_DONE;
                    end else if (wd_d == WD_LIMIT) begin
                        timeout_q <= 1'b1;
                        gap_q     <= '0;
                        state_q   <= GAP;
                    end else begin
                        wd_q <= wd_d;
                    end
                end
                WAIT_DONE: begin
                    // tx_done and a busy fall in the same cycle are one completion.
                    if (tx_done || (busy_q && !tx_busy)) begin
                        gap_q   <= '0;
                        state_q <= GAP;
                    end else if (wd_d == WD_LIMIT) begin
                        timeout_q <= 1'b1;
                        gap_q     <= '0;
                        state_q   <= GAP;
                    end else begin
                        wd_q <= wd_d;
                    end
                end
                GAP: begin
                    if (GAP_TICKS == 0 || (baud_tick && gap_d == GAP_LIMIT)) begin
                        state_q <= IDLE;
`ifdef UART_TX_ARB_LOCK_EN
                        lock_hold_q <= req_lock[grant_q];
`endif
                    end else if (baud_tick) begin
                        gap_q <= gap_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign tx_data      = tx_data_q;
    assign send_request = send_q;
    assign grant_id     = grant_q;
    assign arb_busy     = (state_q != IDLE);
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: NUM_REQ=4, GAP_TICKS=1, TIMEOUT_CYCLES=16.
module tb_uart_tx_arbiter;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        baud_tick = 1'b0;
    logic        tx_busy   = 1'b0;
    logic        tx_done   = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data  = 32'h1312_1110;
`ifdef UART_TX_ARB_LOCK_EN
    logic [3:0]  req_lock  = '0;
`endif
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        send_request;
    logic [1:0]  grant_id;
    logic        arb_busy;
    logic        timeout_err;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned fails  = 0;

    uart_tx_arbiter #(
        .NUM_REQ       (4),
        .GAP_TICKS     (1),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_tick   (baud_tick),
        .req_valid   (req_valid),
        .req_data    (req_data),
`ifdef UART_TX_ARB_LOCK_EN
        .req_lock    (req_lock),
`endif
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .send_request(send_request),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .arb_busy    (arb_busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},   32'(req_ready),    0);
        chk({tag, "_send"},    32'(send_request), 0);
        chk({tag, "_txdata"},  32'(tx_data),      0);
        chk({tag, "_grant"},   32'(grant_id),     0);
        chk({tag, "_busy"},    32'(arb_busy),     0);
        chk({tag, "_timeout"}, 32'(timeout_err),  0);
    endtask

    // One full frame starting from IDLE with the expected winner already requesting.
    task automatic serve(input int id, input int data, input bit fast, input bit drop);
        step();
        chk("ready_pulse", 32'(req_ready),    1 << id);
        chk("grant_id",    32'(grant_id),     id);
        chk("tx_data",     32'(tx_data),      data);
        chk("send_early",  32'(send_request), 0);
        if (drop) req_valid[id] = 1'b0;
        step();
        chk("send_pulse",  32'(send_request), 1);
        chk("ready_clear", 32'(req_ready),    0);
        if (fast) begin
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            chk("gap_busy", 32'(arb_busy), 1);
        end else begin
            tx_busy = 1'b1;
            step();
            step();
            chk("send_once", 32'(send_request), 0);
            chk("data_hold", 32'(tx_data),      data);
            tx_busy = 1'b0;
            step();
            chk("gap_busy",  32'(arb_busy),     1);
        end
        baud_tick = 1'b1;
        step();
        baud_tick = 1'b0;
        chk("back_idle", 32'(arb_busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        repeat (3) step();
        chk_reset_outputs("rst");
        reset = 1'b0;

        // Single byte with a gap that waits for its baud tick.
        req_data[7:0] = 8'hA5;
        req_valid     = 4'b0001;
        step();
        chk("sb_ready",  32'(req_ready),    1);
        chk("sb_send0",  32'(send_request), 0);
        chk("sb_busy",   32'(arb_busy),     1);
        req_valid = '0;
        step();
        chk("sb_send1",  32'(send_request), 1);
        chk("sb_ready0", 32'(req_ready),    0);
        step();
        chk("sb_send2",  32'(send_request), 0);
        tx_busy = 1'b1;
        repeat (3) step();
        chk("sb_hold",   32'(tx_data),      8'hA5);
        tx_busy = 1'b0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("sb_gap",    32'(arb_busy),     1);
        step();
        chk("sb_gapwait", 32'(arb_busy),    1);
        baud_tick = 1'b1;
        step();
        baud_tick = 1'b0;
        chk("sb_idle",   32'(arb_busy),     0);
        req_data[7:0] = 8'h10;

        reset = 1'b1;
        step();
        reset = 1'b0;

        // Round-robin with all requesters held valid.
        req_valid = 4'b1111;
        serve(0, 8'h10, 1'b0, 1'b0);
        serve(1, 8'h11, 1'b1, 1'b0);
        serve(2, 8'h12, 1'b0, 1'b0);
        serve(3, 8'h13, 1'b1, 1'b0);
        serve(0, 8'h10, 1'b0, 1'b0);

        // Wrap: rr lands on 3 after granting 2.
        req_valid = 4'b0101;
        serve(2, 8'h12, 1'b0, 1'b0);
        serve(0, 8'h10, 1'b1, 1'b0);
        serve(2, 8'h12, 1'b0, 1'b1);

        // Watchdog abort with a dead serializer.
        req_valid = 4'b0010;
        step();
        chk("to_ready", 32'(req_ready), 2);
        chk("to_grant", 32'(grant_id),  1);
        req_valid = '0;
        step();
        chk("to_send",  32'(send_request), 1);
        repeat (15) step();
        chk("to_early", 32'(timeout_err), 0);
        chk("to_wait",  32'(arb_busy),    1);
        step();
        chk("to_set",   32'(timeout_err), 1);
        req_valid = 4'b1000;
        baud_tick = 1'b1;
        step();
        baud_tick = 1'b0;
        chk("to_idle",  32'(arb_busy),    0);
        serve(3, 8'h13, 1'b1, 1'b1);
        chk("to_sticky", 32'(timeout_err), 1);

        // Asynchronous reset while waiting for frame completion.
        req_valid = 4'b0010;
        step();
        chk("mr_grant", 32'(grant_id), 1);
        req_valid = '0;
        step();
        tx_busy = 1'b1;
        step();
        step();
        chk("mr_inflight", 32'(arb_busy), 1);
        reset = 1'b1;
        #1;
        chk_reset_outputs("mr");
        tx_busy   = 1'b0;
        req_valid = 4'b0100;
        step();
        reset = 1'b0;
        serve(2, 8'h12, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
